// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched
// Description : Packet-granular round-robin scheduler that shares one UART
//               transmit byte channel among NUM_REQ requesters. It can prefix
//               each packet with a channel-ID header byte, enforces an idle
//               gap after every packet and aborts owners that stall mid-packet.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   mclk         in   system clock
//   reset        in   synchronous, active-high reset
//   cfg_en       in   1 = allow new grants (a packet in flight always finishes)
//   cfg_hdr_en   in   1 = send header {5'b10100, id[2:0]} before each packet
//   req_valid    in   per-requester byte valid
//   req_data     in   per-requester byte, requester i on [8i+7:8i]
//   req_last     in   per-requester "last byte of packet" flag
//   req_ready    out  per-requester accept; only the owner's bit can be set
//   tx_valid     out  byte valid towards the UART TX core
//   tx_data      out  byte towards the UART TX core
//   tx_ready     in   UART TX core accepts the byte
//   grant        out  one-hot current owner, all zero when no owner
//   busy         out  scheduler not idle
//   abort_pulse  out  one-cycle pulse when an owner is aborted for stalling
//   abort_id     out  id of the last aborted requester (held)
// ============================================================================
module uart_tx_sched #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 16,
    parameter int STALL_MAX  = 1024
) (
    input  logic                 mclk,
    input  logic                 reset,
    input  logic                 cfg_en,
    input  logic                 cfg_hdr_en,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 abort_pulse,
    output logic [2:0]           abort_id
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int SW = $clog2(STALL_MAX + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES);
    localparam logic [SW-1:0] STALL_TOP  = SW'(STALL_MAX);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);
    localparam logic [PW-1:0] OWNER_TOP  = PW'(NUM_REQ - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [PW-1:0]      r_owner;
    logic [PW-1:0]      r_ptr;
    logic [GW-1:0]      r_gap;
    logic [SW-1:0]      r_stall;
    logic               r_abort_pulse;
    logic [2:0]         r_abort_id;

    logic               w_sel_found;
    logic [PW-1:0]      w_sel_idx;
    logic               w_grant_now;
    logic               w_own_valid;
    logic               w_own_last;
    logic [7:0]         w_own_data;
    logic [NUM_REQ-1:0] w_owner_onehot;
    logic [7:0]         w_hdr_byte;
    logic               w_xfer;
    logic               w_stall_hit;
    logic               w_leave_data;
    logic [PW-1:0]      w_ptr_next;

    // ------------------------------------------------------------------
    // Owner view of the request bundle
    // ------------------------------------------------------------------
    assign w_own_valid    = req_valid[r_owner];
    assign w_own_last     = req_last[r_owner];
    assign w_own_data     = req_data[{r_owner, 3'b000} +: 8];
    assign w_owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
    assign w_hdr_byte     = {5'b10100, 3'(r_owner)};

    // Round-robin pick: first valid requester at or above the pointer,
    // wrapping around.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_sel_found && req_valid[(int'(r_ptr) + i) % NUM_REQ]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = PW'((int'(r_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign w_grant_now = (r_state == ST_IDLE) && cfg_en && w_sel_found;
    assign w_xfer      = (r_state == ST_DATA) && w_own_valid && tx_ready;
    // Abort fires on the edge that completes STALL_MAX consecutive idle
    // owner cycles, so the counter itself lands on STALL_MAX.
    assign w_stall_hit = (r_state == ST_DATA) && !w_own_valid &&
                         (r_stall == STALL_LAST);
    assign w_leave_data = (r_state == ST_DATA) && (w_next_state == ST_GAP);
    assign w_ptr_next   = (r_owner == OWNER_TOP) ? '0 : r_owner + PW'(1);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                // Header enable only matters here, at grant time.
                if (w_grant_now) begin
                    w_next_state = cfg_hdr_en ? ST_HDR : ST_DATA;
                end
            end
            ST_HDR: begin
                if (tx_ready) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_stall_hit || (w_xfer && w_own_last)) begin
                    w_next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = '0;
        grant     = '0;
        busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_data  = w_hdr_byte;
                grant    = w_owner_onehot;
            end
            ST_DATA: begin
                tx_valid  = w_own_valid;
                tx_data   = w_own_data;
                req_ready = tx_ready ? w_owner_onehot : '0;
                grant     = w_owner_onehot;
            end
            default: begin
                tx_valid = 1'b0;
            end
        endcase
    end

    assign abort_pulse = r_abort_pulse;
    assign abort_id    = r_abort_id;

    // ------------------------------------------------------------------
    // Owner, pointer, counters and abort reporting
    // ------------------------------------------------------------------
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_owner       <= '0;
            r_ptr         <= '0;
            r_gap         <= '0;
            r_stall       <= '0;
            r_abort_pulse <= 1'b0;
            r_abort_id    <= 3'd0;
        end else begin
            if (w_grant_now) begin
                r_owner <= w_sel_idx;
            end

            if (w_leave_data) begin
                r_ptr <= w_ptr_next;
            end

            // Gap counter runs only in GAP and rests at zero elsewhere.
            if ((r_state == ST_GAP) && (r_gap != GAP_LAST)) begin
                r_gap <= r_gap + GW'(1);
            end else begin
                r_gap <= '0;
            end

            // Stall counter: only owner-idle cycles in DATA count; a
            // backpressured byte (valid high, ready low) leaves it alone.
            if ((r_state != ST_DATA) || w_xfer) begin
                r_stall <= '0;
            end else if (!w_own_valid && (r_stall != STALL_TOP)) begin
                r_stall <= r_stall + SW'(1);
            end

            r_abort_pulse <= w_stall_hit;
            if (w_stall_hit) begin
                r_abort_id <= 3'(r_owner);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_sched
// Description : Directed self-checking bench for uart_tx_sched. A packet-level
//               reference model predicts every output on every cycle; literal
//               checks on the captured TX stream pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    localparam int N     = 4;
    localparam int GAP   = 16;
    localparam int STALL = 1024;

    logic           clk = 1'b0;
    logic           reset;
    logic           cfg_en;
    logic           cfg_hdr_en;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           abort_pulse;
    logic [2:0]     abort_id;

    always #5 clk = ~clk;

    uart_tx_sched #(.NUM_REQ(N), .GAP_CYCLES(GAP), .STALL_MAX(STALL)) dut (
        .mclk        (clk),
        .reset       (reset),
        .cfg_en      (cfg_en),
        .cfg_hdr_en  (cfg_hdr_en),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .grant       (grant),
        .busy        (busy),
        .abort_pulse (abort_pulse),
        .abort_id    (abort_id)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Input values the next cycle should carry.
    bit s_reset, s_en, s_hdr, s_rdy;

    // Requester byte queues {last, data}.
    logic [8:0] mem [N][32];
    int         rd [N];
    int         wr [N];

    // Captured TX stream.
    logic [7:0] log_b   [64];
    int         log_cyc [64];
    int         log_n;

    // Packet-level reference model.
    int         m_owner;     // -1 = nobody owns the channel
    bit         m_hdr_due;   // header byte still owed for current packet
    int         m_gap_left;  // cycles of enforced silence remaining
    int         m_ptr;
    int         m_stall;
    bit         m_pulse;
    logic [2:0] m_abid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input bit last);
        mem[r][wr[r]] = {last, d};
        wr[r]++;
    endtask

    task automatic clear_q();
        for (int i = 0; i < N; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
    endtask

    task automatic clear_log();
        log_n = 0;
        for (int i = 0; i < 64; i++) begin
            log_b[i]   = 'x;
            log_cyc[i] = 0;
        end
    endtask

    task automatic model_reset();
        m_owner    = -1;
        m_hdr_due  = 1'b0;
        m_gap_left = 0;
        m_ptr      = 0;
        m_stall    = 0;
        m_pulse    = 1'b0;
        m_abid     = 3'd0;
    endtask

    task automatic drive();
        reset      = s_reset;
        cfg_en     = s_en;
        cfg_hdr_en = s_hdr;
        tx_ready   = s_rdy;
        for (int i = 0; i < N; i++) begin
            if (rd[i] < wr[i]) begin
                req_valid[i]       = 1'b1;
                req_last[i]        = mem[i][rd[i]][8];
                req_data[8*i +: 8] = mem[i][rd[i]][7:0];
            end else begin
                req_valid[i]       = 1'b0;
                req_last[i]        = 1'b0;
                req_data[8*i +: 8] = 8'h00;
            end
        end
    endtask

    task automatic compare();
        logic [N-1:0] eg;
        logic [N-1:0] er;
        logic         ev;
        logic [7:0]   ed;
        logic         eb;
        eg = '0;
        er = '0;
        ev = 1'b0;
        ed = 8'h00;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            if (m_hdr_due) begin
                ev = 1'b1;
                ed = 8'hA0 | 8'(m_owner);
            end else begin
                ev = req_valid[m_owner];
                ed = req_data[8*m_owner +: 8];
                if (tx_ready) er[m_owner] = 1'b1;
            end
        end
        eb = (m_owner >= 0) || (m_gap_left > 0);
        chk("grant",       32'(grant),       32'(eg));
        chk("req_ready",   32'(req_ready),   32'(er));
        chk("tx_valid",    32'(tx_valid),    32'(ev));
        chk("tx_data",     32'(tx_data),     32'(ed));
        chk("busy",        32'(busy),        32'(eb));
        chk("abort_pulse", 32'(abort_pulse), 32'(m_pulse));
        chk("abort_id",    32'(abort_id),    32'(m_abid));
        if (tx_valid === 1'b1 && tx_ready && log_n < 64) begin
            log_b[log_n]   = tx_data;
            log_cyc[log_n] = cyc;
            log_n++;
        end
    endtask

    task automatic end_packet();
        m_ptr      = (m_owner + 1) % N;
        m_owner    = -1;
        m_gap_left = GAP + 1;
    endtask

    task automatic advance();
        if (reset) begin
            model_reset();
            return;
        end
        m_pulse = 1'b0;
        if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (m_owner < 0) begin
            if (cfg_en && (req_valid != '0)) begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && req_valid[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                    end
                end
                m_hdr_due = cfg_hdr_en;
                m_stall   = 0;
            end
        end else if (m_hdr_due) begin
            if (tx_ready) m_hdr_due = 1'b0;
        end else if (req_valid[m_owner]) begin
            if (tx_ready) begin
                rd[m_owner]++;
                m_stall = 0;
                if (req_last[m_owner]) end_packet();
            end
        end else begin
            m_stall++;
            if (m_stall >= STALL) begin
                m_pulse = 1'b1;
                m_abid  = 3'(m_owner);
                end_packet();
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        cyc++;
        compare();
        advance();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_until_log(input int n, input int budget);
        int k;
        k = 0;
        while (log_n < n && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (log_n < n) begin
            errors++;
            $display("FAIL tx_stream_timeout: got %0d bytes, want %0d", log_n, n);
        end
    endtask

    task automatic do_reset();
        s_reset = 1'b1;
        tick();
        clear_q();
        tick();
        s_reset = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_grant"},       32'(grant),       32'h0);
        chk({tag, "_req_ready"},   32'(req_ready),   32'h0);
        chk({tag, "_tx_valid"},    32'(tx_valid),    32'h0);
        chk({tag, "_tx_data"},     32'(tx_data),     32'h0);
        chk({tag, "_busy"},        32'(busy),        32'h0);
        chk({tag, "_abort_pulse"}, 32'(abort_pulse), 32'h0);
        chk({tag, "_abort_id"},    32'(abort_id),    32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int npulse;
        int pulse_cyc;
        int xfer_cyc;

        s_reset = 1'b1; s_en = 1'b1; s_hdr = 1'b1; s_rdy = 1'b1;
        clear_q();
        clear_log();
        model_reset();
        drive();

        // Reset state
        run(3);
        chk_reset_values("rst");
        s_reset = 1'b0;

        // Single requester 1 with header, then a second packet to measure the gap
        push(1, 8'h11, 0); push(1, 8'h22, 0); push(1, 8'h33, 1); push(1, 8'h44, 1);
        clear_log();
        run(2);
        chk("t1_grant",    32'(grant),    32'h2);
        chk("t1_tx_valid", 32'(tx_valid), 32'h1);
        chk("t1_tx_data",  32'(tx_data),  32'hA1);
        run_until_log(6, 80);
        chk("t1_b0", 32'(log_b[0]), 32'hA1);
        chk("t1_b1", 32'(log_b[1]), 32'h11);
        chk("t1_b2", 32'(log_b[2]), 32'h22);
        chk("t1_b3", 32'(log_b[3]), 32'h33);
        chk("t1_b4", 32'(log_b[4]), 32'hA1);
        chk("t1_b5", 32'(log_b[5]), 32'h44);
        chk("t1_gap_ge16", 32'((log_cyc[4] - log_cyc[3] - 1) >= GAP), 32'h1);
        run(25);

        // Requesters 0 and 2 valid from reset, no header
        s_reset = 1'b1;
        tick();
        clear_q();
        s_hdr = 1'b0;
        push(0, 8'h01, 0); push(0, 8'h02, 1);
        push(2, 8'h21, 0); push(2, 8'h22, 1);
        tick();
        s_reset = 1'b0;
        clear_log();
        run_until_log(4, 80);
        chk("t2_b0", 32'(log_b[0]), 32'h01);
        chk("t2_b1", 32'(log_b[1]), 32'h02);
        chk("t2_b2", 32'(log_b[2]), 32'h21);
        chk("t2_b3", 32'(log_b[3]), 32'h22);
        run(25);
        // Pointer now sits at 3: requester 3 beats requester 0
        push(0, 8'h03, 1); push(3, 8'h31, 1);
        run(2);
        chk("t2_grant3", 32'(grant), 32'h8);
        run_until_log(6, 80);
        chk("t2_b4", 32'(log_b[4]), 32'h31);
        chk("t2_b5", 32'(log_b[5]), 32'h03);
        run(25);

        // Header under toggling tx_ready
        do_reset();
        s_hdr = 1'b1;
        push(0, 8'h05, 0); push(0, 8'h06, 0); push(0, 8'h07, 1);
        clear_log();
        for (int k = 0; k < 30; k++) begin
            s_rdy = ((k % 6) >= 3);
            tick();
        end
        s_rdy = 1'b1;
        run_until_log(4, 60);
        run(25);
        chk("t3_b0",    32'(log_b[0]), 32'hA0);
        chk("t3_b1",    32'(log_b[1]), 32'h05);
        chk("t3_b2",    32'(log_b[2]), 32'h06);
        chk("t3_b3",    32'(log_b[3]), 32'h07);
        chk("t3_count", 32'(log_n),    32'd4);

        // Owner 3 stalls after one byte
        do_reset();
        s_hdr = 1'b0;
        push(3, 8'h31, 0);
        clear_log();
        run_until_log(1, 10);
        xfer_cyc  = log_cyc[0];
        push(0, 8'h0A, 1);
        npulse    = 0;
        pulse_cyc = 0;
        for (int k = 0; k < STALL + 20; k++) begin
            tick();
            if (abort_pulse === 1'b1) begin
                npulse++;
                if (npulse == 1) begin
                    pulse_cyc = cyc;
                    chk("t4_abort_id",    32'(abort_id), 32'd3);
                    chk("t4_grant_clear", 32'(grant),    32'h0);
                end
            end
        end
        chk("t4_pulse_count", 32'(npulse), 32'd1);
        chk("t4_pulse_time",  32'(pulse_cyc - xfer_cyc), 32'(STALL + 1));
        push(3, 8'h32, 1);
        run_until_log(3, 100);
        chk("t4_b1", 32'(log_b[1]), 32'h0A);
        chk("t4_b2", 32'(log_b[2]), 32'h32);
        chk("t4_abort_id_held", 32'(abort_id), 32'd3);
        run(25);

        // cfg_en dropped mid-packet
        do_reset();
        s_hdr = 1'b1;
        push(1, 8'h11, 0); push(1, 8'h12, 0); push(1, 8'h13, 0); push(1, 8'h14, 1);
        push(2, 8'h21, 1);
        clear_log();
        run(2);
        chk("t5_grant1", 32'(grant), 32'h2);
        s_en = 1'b0;
        run(60);
        chk("t5_count", 32'(log_n),    32'd5);
        chk("t5_b0",    32'(log_b[0]), 32'hA1);
        chk("t5_b4",    32'(log_b[4]), 32'h14);
        chk("t5_grant_off", 32'(grant), 32'h0);
        chk("t5_busy_off",  32'(busy),  32'h0);
        s_en = 1'b1;
        run(2);
        chk("t5_grant2", 32'(grant), 32'h4);
        run(40);

        // Reset during DATA, pointer returns to 0
        do_reset();
        s_hdr = 1'b0;
        push(2, 8'h20, 1);
        clear_log();
        run_until_log(1, 10);
        run(25);
        push(2, 8'h21, 0); push(2, 8'h22, 0); push(2, 8'h23, 1);
        s_rdy = 1'b0;
        run(4);
        chk("t6_busy_data",  32'(busy),  32'h1);
        chk("t6_grant_data", 32'(grant), 32'h4);
        s_reset = 1'b1;
        tick();
        s_reset = 1'b0;
        clear_q();
        tick();
        chk_reset_values("t6");
        s_rdy = 1'b1;
        push(1, 8'h41, 1); push(3, 8'h43, 1);
        run(2);
        chk("t6_grant_ptr0", 32'(grant), 32'h2);
        run(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
